// File: rtl/pic_control_unit.sv
// PIC16 control unit: Q1..Q4 phase sequencer, instruction register, decoder and skip/flush logic.
// Define CU_CALL_STACK_EN to enable CALL/RETURN/RETLW and the call-stack pointer.

package pic_cu_pkg;
    typedef enum logic [3:0] {
        ALU_NOP    = 4'd0,
        ALU_ADD    = 4'd1,
        ALU_SUB    = 4'd2,
        ALU_AND    = 4'd3,
        ALU_IOR    = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_PASSLF = 4'd6,
        ALU_PASSW  = 4'd7,
        ALU_CLR    = 4'd8,
        ALU_COM    = 4'd9,
        ALU_INC    = 4'd10,
        ALU_DEC    = 4'd11,
        ALU_RLF    = 4'd12,
        ALU_RRF    = 4'd13,
        ALU_SWAP   = 4'd14
    } alu_op_e;

    typedef enum logic [1:0] {
        Q1 = 2'd0,
        Q2 = 2'd1,
        Q3 = 2'd2,
        Q4 = 2'd3
    } q_phase_e;
endpackage

module pic_control_unit
    import pic_cu_pkg::*;
#(
    parameter int PC_W    = 11,
    parameter int STACK_D = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [13:0]                instr_in,
    input  logic                       alu_out_z,
    input  logic                       alu_bit_test_res,
    output logic [1:0]                 q_phase,
    output logic [3:0]                 alu_op,
    output logic                       alu_d,
    output logic                       alu_d_wr_en,
    output logic                       alu_status_wr_en,
    output logic                       lf_sel_lit,
    output logic [6:0]                 f_addr,
    output logic [7:0]                 literal,
    output logic [2:0]                 bit_idx,
    output logic                       bit_wr_en,
    output logic                       bit_val,
    output logic                       pc_inc,
    output logic                       pc_load,
    output logic [PC_W-1:0]            pc_load_val,
    output logic                       stack_push,
    output logic                       stack_pop,
    output logic [$clog2(STACK_D)-1:0] stack_ptr,
    output logic                       illegal_instr
);

    q_phase_e    q_state, q_next;
    logic [13:0] ir;
    logic        flush;
    logic        is_q4;
    logic        set_flush;

    alu_op_e dec_op;
    logic    dec_d, dec_lf, dec_wr, dec_st, dec_bit_wr;
    logic    dec_load, dec_branch, dec_illegal;
    logic    dec_skip_z, dec_skip_clr, dec_skip_set;
`ifdef CU_CALL_STACK_EN
    logic    dec_push, dec_pop;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) q_state <= Q1;
        else     q_state <= q_next;
    end

    always_comb begin
        case (q_state)
            Q1:      q_next = Q2;
            Q2:      q_next = Q3;
            Q3:      q_next = Q4;
            default: q_next = Q1;
        endcase
    end

    // Fetch and skip bookkeeping both advance only at the end of Q4.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir    <= '0;
            flush <= 1'b1;
        end else if (q_state == Q4) begin
            ir    <= instr_in;
            flush <= set_flush;
        end
    end

    // NOTE: every signal gets a default first so no path through the decoder can infer a latch.
    always_comb begin
        dec_op       = ALU_NOP;
        dec_d        = 1'b0;
        dec_lf       = 1'b0;
        dec_wr       = 1'b0;
        dec_st       = 1'b0;
        dec_bit_wr   = 1'b0;
        dec_load     = 1'b0;
        dec_branch   = 1'b0;
        dec_illegal  = 1'b0;
        dec_skip_z   = 1'b0;
        dec_skip_clr = 1'b0;
        dec_skip_set = 1'b0;
`ifdef CU_CALL_STACK_EN
        dec_push     = 1'b0;
        dec_pop      = 1'b0;
`endif
        if (!flush) begin
            case (ir[13:12])
                2'b00: begin
                    if (ir[11:8] == 4'h0) begin
                        if (ir[7]) begin
                            dec_op = ALU_PASSW;
                            dec_d  = 1'b1;
                            dec_wr = 1'b1;
                        end else if (ir[6:0] == 7'h08) begin
`ifdef CU_CALL_STACK_EN
                            dec_pop    = 1'b1;
                            dec_branch = 1'b1;
`else
                            dec_illegal = 1'b1;
`endif
                        end else if (ir[4:0] != 5'h00) begin
                            dec_illegal = 1'b1;
                        end
                    end else begin
                        dec_d  = ir[7];
                        dec_wr = 1'b1;
                        dec_st = 1'b1;
                        case (ir[11:8])
                            4'h1: dec_op = ALU_CLR;
                            4'h2: dec_op = ALU_SUB;
                            4'h3: dec_op = ALU_DEC;
                            4'h4: dec_op = ALU_IOR;
                            4'h5: dec_op = ALU_AND;
                            4'h6: dec_op = ALU_XOR;
                            4'h7: dec_op = ALU_ADD;
                            4'h8: dec_op = ALU_PASSLF;
                            4'h9: dec_op = ALU_COM;
                            4'hA: dec_op = ALU_INC;
                            4'hB: begin
                                dec_op     = ALU_DEC;
                                dec_st     = 1'b0;
                                dec_skip_z = 1'b1;
                            end
                            4'hC: dec_op = ALU_RRF;
                            4'hD: dec_op = ALU_RLF;
                            4'hE: begin
                                dec_op = ALU_SWAP;
                                dec_st = 1'b0;
                            end
                            4'hF: begin
                                dec_op     = ALU_INC;
                                dec_st     = 1'b0;
                                dec_skip_z = 1'b1;
                            end
                            default: dec_op = ALU_NOP;
                        endcase
                    end
                end
                2'b01: begin
                    case (ir[11:10])
                        2'b10:   dec_skip_clr = 1'b1;
                        2'b11:   dec_skip_set = 1'b1;
                        default: dec_bit_wr   = 1'b1;
                    endcase
                end
                2'b10: begin
                    if (ir[11]) begin
                        dec_load   = 1'b1;
                        dec_branch = 1'b1;
                    end else begin
`ifdef CU_CALL_STACK_EN
                        dec_push   = 1'b1;
                        dec_load   = 1'b1;
                        dec_branch = 1'b1;
`else
                        dec_illegal = 1'b1;
`endif
                    end
                end
                default: begin
                    // An all-ones word is erased program memory, not ADDLW 0xFF (that is 14'h3EFF).
                    if (&ir) begin
                        dec_illegal = 1'b1;
                    end else begin
                        dec_lf = 1'b1;
                        dec_wr = 1'b1;
                        dec_st = 1'b1;
                        casez (ir[11:8])
                            4'b00??: begin
                                dec_op = ALU_PASSLF;
                                dec_st = 1'b0;
                            end
                            4'b01??: begin
`ifdef CU_CALL_STACK_EN
                                dec_op     = ALU_PASSLF;
                                dec_st     = 1'b0;
                                dec_pop    = 1'b1;
                                dec_branch = 1'b1;
`else
                                dec_lf      = 1'b0;
                                dec_wr      = 1'b0;
                                dec_st      = 1'b0;
                                dec_illegal = 1'b1;
`endif
                            end
                            4'b1000: dec_op = ALU_IOR;
                            4'b1001: dec_op = ALU_AND;
                            4'b1010: dec_op = ALU_XOR;
                            4'b110?: dec_op = ALU_SUB;
                            4'b111?: dec_op = ALU_ADD;
                            default: begin
                                dec_lf      = 1'b0;
                                dec_wr      = 1'b0;
                                dec_st      = 1'b0;
                                dec_illegal = 1'b1;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    // A reset in Q4 must suppress every strobe of the aborted instruction.
    always_comb begin
        is_q4            = (q_state == Q4) && !rst;
        alu_d_wr_en      = is_q4 & dec_wr;
        alu_status_wr_en = is_q4 & dec_st;
        bit_wr_en        = is_q4 & dec_bit_wr;
        pc_inc           = is_q4 & ~dec_branch;
        pc_load          = is_q4 & dec_load;
        illegal_instr    = is_q4 & dec_illegal;
`ifdef CU_CALL_STACK_EN
        stack_push       = is_q4 & dec_push;
        stack_pop        = is_q4 & dec_pop;
`else
        stack_push       = 1'b0;
        stack_pop        = 1'b0;
`endif
        set_flush = dec_branch
                  | (dec_skip_z   &  alu_out_z)
                  | (dec_skip_clr & ~alu_bit_test_res)
                  | (dec_skip_set &  alu_bit_test_res);
    end

    assign q_phase     = q_state;
    assign alu_op      = dec_op;
    assign alu_d       = dec_d;
    assign lf_sel_lit  = dec_lf;
    assign f_addr      = ir[6:0];
    assign literal     = ir[7:0];
    assign bit_idx     = ir[9:7];
    assign bit_val     = ir[10];
    assign pc_load_val = ir[PC_W-1:0];

`ifdef CU_CALL_STACK_EN
    localparam int SP_W = $clog2(STACK_D);
    localparam logic [SP_W-1:0] SP_MAX = SP_W'(STACK_D - 1);

    logic [SP_W-1:0] sp;

    always_ff @(posedge clk) begin
        if (rst)             sp <= '0;
        else if (stack_push) sp <= (sp == SP_MAX) ? '0 : sp + 1'b1;
        else if (stack_pop)  sp <= (sp == '0) ? SP_MAX : sp - 1'b1;
    end

    assign stack_ptr = sp;
`else
    assign stack_ptr = '0;
`endif

endmodule
